// File: rtl/axil_rdata_channel_if.sv
// Signal bundle between the AXI4-Lite read-data channel, the read-address
// block that feeds it, the memory array and the AXI master.
//
// Handshake semantics: a transfer on a VALID/READY (or VALID/TAKEN) pair
// happens in a cycle where both are high at the rising clock edge; once the
// source raises VALID it keeps VALID and its payload stable until that
// cycle. RRESPREADY and MEMRDEN are one-cycle strobes with no back-pressure.
interface axil_rdata_channel_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // read-address block side
    logic                  ADDRVALID;
    logic [ADDR_WIDTH-1:0] ADDRIN;
    logic                  ADDRTAKEN;
    // memory side
    logic                  MEMRDEN;
    logic [ADDR_WIDTH-1:0] MEMADDR;
    logic [DATA_WIDTH-1:0] MEMRDATA;
    logic                  MEMRVALID;
    logic                  MEMRERR;
    // AXI master side
    logic                  RVALID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RREADY;
    // completion report to the read-address block
    logic                  RRESPREADY;
    logic [1:0]            RSTATUS;
    // FSM state for observation (0 IDLE, 1 FETCH, 2 RESP)
    logic [1:0]            DBGSTATE;

    modport slave (
        input  ADDRVALID, ADDRIN, MEMRDATA, MEMRVALID, MEMRERR, RREADY,
        output ADDRTAKEN, MEMRDEN, MEMADDR, RVALID, RDATA, RRESP,
               RRESPREADY, RSTATUS, DBGSTATE
    );

    modport master (
        output ADDRVALID, ADDRIN, MEMRDATA, MEMRVALID, MEMRERR, RREADY,
        input  ADDRTAKEN, MEMRDEN, MEMADDR, RVALID, RDATA, RRESP,
               RRESPREADY, RSTATUS, DBGSTATE
    );
endinterface

// File: rtl/axil_rdata_channel.sv
// AXI4-Lite slave read-data channel: takes a captured read address, fetches
// the word from memory (with a bounded wait) and returns RDATA/RRESP to the
// master, then pulses a completion status back to the read-address block.
module axil_rdata_channel #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32,
    parameter int TIMEOUT    = 16
) (
    input logic                 clk,
    input logic                 resetn,
    axil_rdata_channel_if.slave bus
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Counter has one spare bit so it can hold TIMEOUT-1 for any TIMEOUT.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TIMEOUT - 1);
    // One extra bit lets MEM_DEPTH == 2**ADDR_WIDTH be represented.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_memrden;
    logic [ADDR_WIDTH-1:0] r_memaddr;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rrespready;
    logic [1:0]            r_rstatus;

    logic                  w_addr_oor;

    // Addresses past the populated word range decode-error without touching memory.
    always_comb w_addr_oor = ({1'b0, bus.ADDRIN} >= LP_DEPTH);

    // Address is taken only while idle, and never while reset is held.
    always_comb bus.ADDRTAKEN = resetn && (r_state == S_IDLE) && bus.ADDRVALID;

    // Drive the registered outputs onto the bundle.
    always_comb begin
        bus.MEMRDEN    = r_memrden;
        bus.MEMADDR    = r_memaddr;
        bus.RVALID     = r_rvalid;
        bus.RDATA      = r_rdata;
        bus.RRESP      = r_rresp;
        bus.RRESPREADY = r_rrespready;
        bus.RSTATUS    = r_rstatus;
        bus.DBGSTATE   = r_state;
    end

    // Transfer FSM: IDLE -> (FETCH ->) RESP -> IDLE, all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_memrden    <= 1'b0;
            r_memaddr    <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_rrespready <= 1'b0;
            r_rstatus    <= RESP_OKAY;
        end else begin
            r_memrden    <= 1'b0;
            r_rrespready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ADDRVALID) begin
                        r_memaddr <= bus.ADDRIN;
                        if (w_addr_oor) begin
                            r_rdata  <= '0;
                            r_rresp  <= RESP_DECERR;
                            r_rvalid <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_memrden <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Data arriving on the final wait cycle still wins over the timeout.
                    if (bus.MEMRVALID) begin
                        r_rdata  <= bus.MEMRDATA;
                        r_rresp  <= bus.MEMRERR ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rdata  <= '0;
                        r_rresp  <= RESP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus.RREADY) begin
                        r_rvalid     <= 1'b0;
                        r_rrespready <= 1'b1;
                        r_rstatus    <= r_rresp;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
